// File: rtl/fs_nand_serial.sv
`default_nettype none
// ============================================================================
// Module   : fs_nand_serial
// Function : Bit-serial a - b - bin, LSB first, using a NAND-only full-subtractor
//            cell and a borrow flip-flop.
// Revision : 1.0
// ============================================================================
module fs_nand_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             a_msb_q, b_msb_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, ovf_q;

  // Full-subtractor cell, 2-input NANDs only
  logic w_x0, w_na, w_nb, w_axb;
  logic w_y0, w_ya, w_yb, w_d;
  logic w_inv_a, w_t1, w_inv_x, w_t2, w_bo;
  logic [WIDTH-1:0] w_res;

  assign w_x0    = ~(a_sh_q[0] & b_sh_q[0]);
  assign w_na    = ~(a_sh_q[0] & w_x0);
  assign w_nb    = ~(b_sh_q[0] & w_x0);
  assign w_axb   = ~(w_na & w_nb);
  assign w_y0    = ~(w_axb & br_q);
  assign w_ya    = ~(w_axb & w_y0);
  assign w_yb    = ~(br_q & w_y0);
  assign w_d     = ~(w_ya & w_yb);
  assign w_inv_a = ~(a_sh_q[0] & a_sh_q[0]);
  assign w_t1    = ~(w_inv_a & b_sh_q[0]);
  assign w_inv_x = ~(w_axb & w_axb);
  assign w_t2    = ~(w_inv_x & br_q);
  assign w_bo    = ~(w_t1 & w_t2);

  assign w_res = {w_d, res_q};

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == C_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          a_sh_q  <= a;
          b_sh_q  <= b;
          br_q    <= bin;
          cnt_q   <= '0;
          a_msb_q <= a[WIDTH-1];
          b_msb_q <= b[WIDTH-1];
        end
        S_RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= w_bo;
          res_q  <= w_res[WIDTH-1:1];
          cnt_q  <= cnt_q + 1'b1;
          // Results are published only when the MSB cell completes
          if (cnt_q == C_LAST) begin
            diff_q <= w_res;
            bout_q <= w_bo;
            ovf_q  <= (a_msb_q ^ b_msb_q) & (w_d ^ a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire
